// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS types, control tokens and popcount helper
package tmds_pkg;

  typedef logic signed [4:0] tmds_disp_t;

  // Indexed by {c1,c0}; the decoder matches against the same table.
  localparam logic [9:0] TMDS_CTRL_TOKEN [4] = '{
    10'b1101010100,
    10'b0010101011,
    10'b0101010100,
    10'b1010101011
  };

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_encoder.sv
// rtl/tmds_encoder.sv - two-stage DVI TMDS 8b/10b encoder with running disparity
module tmds_encoder
  import tmds_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       de_i,
  input  logic       c1_i,
  input  logic       c0_i,
  input  logic [7:0] d_i,
  output logic [9:0] q_o
);

  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] q_m_d;

  logic       de_q;
  logic [1:0] c_q;
  logic [8:0] q_m_q;

  logic [3:0] n1q;
  logic [3:0] n0q;
  tmds_disp_t diff;
  tmds_disp_t cnt_q;
  tmds_disp_t cnt_d;
  logic       cnt_pos;
  logic       cnt_neg;
  logic [9:0] q_d;

  // Stage 1: transition-minimising chain, XNOR chosen when it yields fewer edges.
  always_comb begin
    n1d      = popcount8(d_i);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d_i[0]);
    q_m_d    = '0;
    q_m_d[0] = d_i[0];
    for (int i = 1; i < 8; i++) begin
      q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ d_i[i]) : (q_m_d[i-1] ^ d_i[i]);
    end
    q_m_d[8] = ~use_xnor;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      de_q  <= 1'b0;
      c_q   <= 2'b00;
      q_m_q <= '0;
    end else begin
      de_q  <= de_i;
      c_q   <= {c1_i, c0_i};
      q_m_q <= q_m_d;
    end
  end

  // Stage 2: choose inversion to steer the running disparity back toward zero.
  always_comb begin
    n1q     = popcount8(q_m_q[7:0]);
    n0q     = 4'd8 - n1q;
    diff    = $signed({1'b0, n1q}) - $signed({1'b0, n0q});
    cnt_pos = !cnt_q[4] && (cnt_q != '0);
    cnt_neg = cnt_q[4];
    q_d     = TMDS_CTRL_TOKEN[c_q];
    cnt_d   = '0;
    if (de_q) begin
      if ((cnt_q == '0) || (n1q == n0q)) begin
        q_d   = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
        cnt_d = q_m_q[8] ? (cnt_q + diff) : (cnt_q - diff);
      end else if ((cnt_pos && (n1q > n0q)) || (cnt_neg && (n0q > n1q))) begin
        q_d   = {1'b1, q_m_q[8], ~q_m_q[7:0]};
        cnt_d = cnt_q + (q_m_q[8] ? 5'sd2 : 5'sd0) - diff;
      end else begin
        q_d   = {1'b0, q_m_q[8], q_m_q[7:0]};
        cnt_d = cnt_q - (q_m_q[8] ? 5'sd0 : 5'sd2) + diff;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      q_o   <= TMDS_CTRL_TOKEN[0];
      cnt_q <= '0;
    end else begin
      q_o   <= q_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tmds_encoder.sv
// tb/tb_tmds_encoder.sv - randomized self-checking bench for tmds_encoder
module tb_tmds_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       de = 1'b0;
  logic       c1 = 1'b0;
  logic       c0 = 1'b0;
  logic [7:0] d = 8'h00;
  logic [9:0] q;

  int checks = 0;
  int errors = 0;

  logic [9:0] tok [4];

  tmds_encoder dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .de_i   (de),
    .c1_i   (c1),
    .c0_i   (c0),
    .d_i    (d),
    .q_o    (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  function automatic int ones10(input logic [9:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) n += int'(v[i]);
    return n;
  endfunction

  // Reference model: disparity is tracked as the ones-minus-zeros of emitted characters.
  int         m_cnt = 0;
  logic       s1_de = 1'b0;
  logic [1:0] s1_c = 2'b00;
  logic [7:0] s1_d = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_is_data = 1'b0;
  logic [9:0] exp_q = 10'b0;
  logic [7:0] exp_d = 8'h00;
  int         obs_disp = 0;

  task automatic model_encode(input logic [7:0] din, output logic [9:0] out);
    logic [8:0] qm;
    int         n1d;
    int         n1;
    logic       xn;
    logic       inv;
    n1d = 0;
    for (int i = 0; i < 8; i++) n1d += int'(din[i]);
    xn = (n1d > 4) || (n1d == 4 && din[0] == 1'b0);
    qm[0] = din[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ din[i]) : (qm[i-1] ^ din[i]);
    qm[8] = ~xn;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
    if (m_cnt == 0 || n1 == 4) inv = ~qm[8];
    else if ((m_cnt > 0 && n1 > 4) || (m_cnt < 0 && n1 < 4)) inv = 1'b1;
    else inv = 1'b0;
    out = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    m_cnt += 2 * ones10(out) - 10;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q       = tok[0];
      exp_is_data = 1'b0;
      m_cnt       = 0;
      s1_de       = 1'b0;
      s1_c        = 2'b00;
      s1_d        = 8'h00;
      exp_valid   = 1'b1;
    end else begin
      exp_is_data = s1_de;
      exp_d       = s1_d;
      if (!s1_de) begin
        exp_q = tok[s1_c];
        m_cnt = 0;
      end else begin
        model_encode(s1_d, exp_q);
      end
      s1_de = de;
      s1_c  = {c1, c0};
      s1_d  = d;
    end
  end

  always @(negedge clk) begin : compare
    logic [7:0] x;
    logic [7:0] dec;
    if (exp_valid) begin
      check("q_vs_model", q, exp_q);
      if (exp_is_data) begin
        obs_disp += 2 * ones10(q) - 10;
        checks++;
        if (obs_disp > 8 || obs_disp < -8) begin
          errors++;
          $display("FAIL disparity_bound got %0d want -8..8", obs_disp);
        end
        x = q[9] ? ~q[7:0] : q[7:0];
        dec[0] = x[0];
        for (int i = 1; i < 8; i++) dec[i] = q[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
        check("loopback_data", {2'b00, dec}, {2'b00, exp_d});
      end else begin
        obs_disp = 0;
      end
    end
  end

  task automatic cycle(input logic r, input logic e, input logic [1:0] c, input logic [7:0] dd);
    @(negedge clk);
    rst_n    = r;
    de       = e;
    {c1, c0} = c;
    d        = dd;
  endtask

  initial begin
    int         run;
    logic       cur_de;
    logic [9:0] zero_seq [4];
    logic [7:0] rd;
    tok[0] = 10'b1101010100;
    tok[1] = 10'b0010101011;
    tok[2] = 10'b0101010100;
    tok[3] = 10'b1010101011;
    zero_seq[0] = 10'b0100000000;
    zero_seq[1] = 10'b1111111111;
    zero_seq[2] = 10'b0100000000;
    zero_seq[3] = 10'b1111111111;

    // Reset held with arbitrary inputs.
    cycle(1'b0, 1'b1, 2'b11, 8'($urandom));
    cycle(1'b0, 1'b1, 2'b10, 8'($urandom));
    check("reset_1", q, 10'b1101010100);
    cycle(1'b0, 1'b1, 2'b01, 8'($urandom));
    check("reset_2", q, 10'b1101010100);

    // Control tokens.
    cycle(1'b1, 1'b0, 2'b01, 8'h5A);
    cycle(1'b1, 1'b0, 2'b10, 8'hA5);
    cycle(1'b1, 1'b0, 2'b11, 8'h3C);
    check("ctrl_01", q, 10'b0010101011);
    cycle(1'b1, 1'b0, 2'b00, 8'h00);
    check("ctrl_10", q, 10'b0101010100);
    cycle(1'b1, 1'b0, 2'b00, 8'h00);
    check("ctrl_11", q, 10'b1010101011);

    // 0x00 stream from cnt=0.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 2'b00, 8'h00);
      if (i >= 2) check($sformatf("zero_stream_%0d", i - 2), q, zero_seq[i-2]);
    end

    // 0xFF stream after a control gap.
    cycle(1'b1, 1'b0, 2'b00, 8'h00);
    cycle(1'b1, 1'b0, 2'b00, 8'h00);
    cycle(1'b1, 1'b1, 2'b00, 8'hFF);
    cycle(1'b1, 1'b1, 2'b00, 8'hFF);
    cycle(1'b1, 1'b1, 2'b00, 8'hFF);
    check("ff_stream_0", q, 10'b1000000000);
    cycle(1'b1, 1'b1, 2'b00, 8'hFF);
    check("ff_stream_1", q, 10'b0011111111);

    // Mid-stream reset with cnt=-6.
    cycle(1'b1, 1'b0, 2'b00, 8'h00);
    cycle(1'b1, 1'b0, 2'b00, 8'h00);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 2'b00, 8'h00);
    cycle(1'b0, 1'b1, 2'b11, 8'($urandom));
    check("pre_reset_cnt_m6", q, 10'b0100000000);
    cycle(1'b1, 1'b1, 2'b00, 8'h00);
    check("reset_pulse_token", q, 10'b1101010100);
    cycle(1'b1, 1'b1, 2'b00, 8'h00);
    cycle(1'b1, 1'b1, 2'b00, 8'h00);
    check("after_reset_first", q, 10'b0100000000);

    // Random bursts with occasional resets.
    run    = 0;
    cur_de = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (run == 0) begin
        cur_de = ~cur_de;
        run    = cur_de ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
      end
      run--;
      case ($urandom_range(0, 5))
        0:       rd = 8'h00;
        1:       rd = 8'hFF;
        default: rd = 8'($urandom);
      endcase
      cycle(($urandom_range(0, 999) != 0), cur_de, 2'($urandom_range(0, 3)), rd);
    end
    cycle(1'b1, 1'b0, 2'b00, 8'h00);
    cycle(1'b1, 1'b0, 2'b00, 8'h00);
    cycle(1'b1, 1'b0, 2'b00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
